// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: ready/valid request from the fetch stage to imem.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC, imem handshake, IF/ID register with a
// one-entry stall hold buffer and redirect handling across outstanding requests.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                jump,
    input  logic [25:0]         jaddress,
    instr_fetch_if.master       imem,
    output logic [31:0]         word,
    output logic [31:0]         pc_plus4,
    output logic                valid
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   hword;
    logic [XLEN-1:0]   hpc4;
    logic [XLEN-1:0]   rtarget;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_inc;

    // Branch wins over jump; jump target is relative to the instruction in ID.
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target
                                   : {pc_plus4[31:28], jaddress, 2'b00};
    assign pc_inc   = pc + XLEN'(4);

    // pc only advances on a completed fetch, so it is the outstanding address in DRAIN too.
    assign imem.imem_req  = !reset && (state != HELD);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            word     <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
            hword    <= '0;
            hpc4     <= '0;
            rtarget  <= '0;
        end else begin
            // Redirect squashes the IF/ID slot to a nop regardless of stall.
            if (redirect) begin
                valid <= 1'b0;
                word  <= '0;
            end

            unique case (state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        if (redirect) begin
                            pc <= target;
                        end else if (!valid || !stall) begin
                            word     <= imem.imem_rdata;
                            pc_plus4 <= pc_inc;
                            valid    <= 1'b1;
                            pc       <= pc_inc;
                        end else begin
                            hword <= imem.imem_rdata;
                            hpc4  <= pc_inc;
                            pc    <= pc_inc;
                            state <= HELD;
                        end
                    end else if (redirect) begin
                        rtarget <= target;
                        state   <= DRAIN;
                    end else if (!stall) begin
                        valid <= 1'b0;
                    end
                end

                HELD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        word     <= hword;
                        pc_plus4 <= hpc4;
                        valid    <= 1'b1;
                        state    <= FETCH;
                    end
                end

                DRAIN: begin
                    // The stale response is discarded; the latest redirect target wins.
                    if (redirect) begin
                        rtarget <= target;
                    end
                    if (imem.imem_ready) begin
                        pc    <= redirect ? target : rtarget;
                        state <= FETCH;
                    end
                    if (!stall && !redirect) begin
                        valid <= 1'b0;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory returns data equal to the address.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jaddress;
    logic        ready;

    logic [31:0] word, pc_plus4;
    logic        valid;
    logic [31:0] word2, pc_plus4_2;
    logic        valid2;

    int tests = 0;
    int fails = 0;
    logic [64:0] got;
    logic [64:0] exp;

    instr_fetch_if bus ();
    instr_fetch_if bus2 ();

    assign bus.imem_rdata  = bus.imem_addr;
    assign bus.imem_ready  = ready;
    assign bus2.imem_rdata = bus2.imem_addr;
    assign bus2.imem_ready = 1'b1;

    instr_fetch dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jaddress(jaddress), .imem(bus),
        .word(word), .pc_plus4(pc_plus4), .valid(valid)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jaddress(26'h0), .imem(bus2),
        .word(word2), .pc_plus4(pc_plus4_2), .valid(valid2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if (bus.imem_req !== 1'b0) begin
            fails++; $display("FAIL reset_req got %b want 0", bus.imem_req);
        end
        got = {valid, word, pc_plus4}; exp = '0;
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL reset_outputs got %h want %h", got, exp);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 5; i++) begin
            step();
            got = {valid, word, pc_plus4};
            exp = {1'b1, 32'(i * 4), 32'(i * 4 + 4)};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL free_run[%0d] got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {valid, word, pc_plus4};
            exp = {1'b1, 32'h10, 32'h14};
            tests++;
            if (got !== exp || bus.imem_req !== 1'b0) begin
                fails++; $display("FAIL stall_hold[%0d] got %h req=%b want %h req=0", i, got, bus.imem_req, exp);
            end
        end
        stall = 1'b0;
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h14, 32'h18};
        tests++;
        if (got !== exp || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h18) begin
            fails++; $display("FAIL stall_release got %h req=%b addr=%h want %h req=1 addr=18", got, bus.imem_req, bus.imem_addr, exp);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h18, 32'h1C};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL stall_after got %h want %h", got, exp);
        end
    endtask

    task automatic test_jump();
        branch_taken  = 1'b1;
        branch_target = 32'h1000_0004;
        step();
        branch_taken = 1'b0;
        tests++;
        if ({valid, word, bus.imem_addr} !== {1'b0, 32'h0, 32'h1000_0004}) begin
            fails++; $display("FAIL branch_squash got v=%b w=%h addr=%h want v=0 w=0 addr=10000004", valid, word, bus.imem_addr);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h1000_0004, 32'h1000_0008};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL branch_first got %h want %h", got, exp);
        end
        jump     = 1'b1;
        jaddress = 26'h0000040;
        step();
        jump = 1'b0;
        tests++;
        if ({valid, word, bus.imem_addr} !== {1'b0, 32'h0, 32'h1000_0100}) begin
            fails++; $display("FAIL jump_squash got v=%b w=%h addr=%h want v=0 w=0 addr=10000100", valid, word, bus.imem_addr);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h1000_0100, 32'h1000_0104};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL jump_first got %h want %h", got, exp);
        end
    endtask

    task automatic test_drain();
        ready         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            branch_taken = 1'b0;
            if (i == 2) ready = 1'b1;
            tests++;
            if ({bus.imem_req, bus.imem_addr, valid} !== {1'b1, 32'h1000_0104, 1'b0}) begin
                fails++; $display("FAIL drain_wait[%0d] got req=%b addr=%h v=%b want req=1 addr=10000104 v=0", i, bus.imem_req, bus.imem_addr, valid);
            end
        end
        step();
        tests++;
        if ({bus.imem_req, bus.imem_addr, valid, word} !== {1'b1, 32'h200, 1'b0, 32'h0}) begin
            fails++; $display("FAIL drain_done got req=%b addr=%h v=%b w=%h want req=1 addr=200 v=0 w=0", bus.imem_req, bus.imem_addr, valid, word);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h200, 32'h204};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL drain_target got %h want %h", got, exp);
        end
    endtask

    task automatic test_branch_jump_stall();
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        jump          = 1'b1;
        jaddress      = 26'h3FF_FFFF;
        stall         = 1'b1;
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        stall        = 1'b0;
        tests++;
        if ({bus.imem_req, bus.imem_addr, valid, word} !== {1'b1, 32'h300, 1'b0, 32'h0}) begin
            fails++; $display("FAIL branch_prio got req=%b addr=%h v=%b w=%h want req=1 addr=300 v=0 w=0", bus.imem_req, bus.imem_addr, valid, word);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h300, 32'h304};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL branch_prio_first got %h want %h", got, exp);
        end
    endtask

    task automatic test_reset_pc_wrap();
        reset2 = 1'b0;
        #1;
        tests++;
        if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            fails++; $display("FAIL wrap_first got req=%b addr=%h want req=1 addr=fffffffc", bus2.imem_req, bus2.imem_addr);
        end
        step();
        got = {valid2, word2, pc_plus4_2}; exp = {1'b1, 32'hFFFF_FFFC, 32'h0};
        tests++;
        if (got !== exp || bus2.imem_addr !== 32'h0) begin
            fails++; $display("FAIL wrap_second got %h addr=%h want %h addr=0", got, bus2.imem_addr, exp);
        end
        step();
        got = {valid2, word2, pc_plus4_2}; exp = {1'b1, 32'h0, 32'h4};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL wrap_third got %h want %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_drain();
        ready         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h400;
        step();
        branch_taken = 1'b0;
        reset        = 1'b1;
        step();
        got = {valid, word, pc_plus4}; exp = '0;
        tests++;
        if (got !== exp || bus.imem_req !== 1'b0) begin
            fails++; $display("FAIL reset_drain got %h req=%b want %h req=0", got, bus.imem_req, exp);
        end
        reset = 1'b0;
        ready = 1'b1;
        #1;
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL reset_drain_req got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
        step();
        got = {valid, word, pc_plus4}; exp = {1'b1, 32'h0, 32'h4};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL reset_drain_fetch got %h want %h", got, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        reset2        = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jaddress      = 26'h0;
        ready         = 1'b1;

        test_reset();
        test_free_run();
        test_stall();
        test_jump();
        test_drain();
        test_branch_jump_stall();
        test_reset_pc_wrap();
        test_reset_mid_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
